suma_control: RTL and testbench

SUMA_CONTROL -- requirements
Module: suma_control

---
 rtl/suma_if.sv | 20 ++
 rtl/suma_control.sv | 93 +++++++++
 tb/tb_suma_control.sv | 139 +++++++++++++
 3 files changed

// File: rtl/suma_if.sv
// suma_if: keypad/adder handshake and operand/display bus for suma_control
interface suma_if #(parameter int N_DIGITS = 3);
  logic key_valid;
  logic [3:0] key_code;
  logic sum_done;
  logic [4*N_DIGITS-1:0] op_a;
  logic [4*N_DIGITS-1:0] op_b;
  logic sum_start;
  logic [1:0] disp_sel;
  logic [2:0] digit_cnt;
  logic error;
  modport master (
    output key_valid, key_code, sum_done,
    input  op_a, op_b, sum_start, disp_sel, digit_cnt, error
  );
  modport slave (
    input  key_valid, key_code, sum_done,
    output op_a, op_b, sum_start, disp_sel, digit_cnt, error
  );
endinterface

// File: rtl/suma_control.sv
// suma_control: BCD two-operand adder front end FSM; define SUMA_BACKSPACE_EN to enable key 0xB backspace
module suma_control #(
  parameter int N_DIGITS = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  suma_if.slave bus
);
  localparam int W = 4 * N_DIGITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {ENT_A, ENT_B, REQ, WAIT, SHOW, ERR} state_t;
  state_t state, state_nx;
  logic [W-1:0] op_a, op_b, cur, shl, shr;
  logic [2:0] digit_cnt;
  logic [TW-1:0] tmo;
  logic digit, clr, plus, eq, entering, in_b, shift, bs, restart;
  logic sum_start, error;
  logic [1:0] disp_sel;
  assign digit = bus.key_valid && bus.key_code <= 4'd9;
  assign clr = bus.key_valid && bus.key_code == 4'hC;
  assign plus = bus.key_valid && bus.key_code == 4'hA;
  assign eq = bus.key_valid && bus.key_code == 4'hE;
  assign entering = state == ENT_A || state == ENT_B;
  assign in_b = state == ENT_B;
  assign cur = in_b ? op_b : op_a;
  assign shl = (cur << 4) | W'(bus.key_code);
  assign shr = cur >> 4;
  assign shift = entering && digit && digit_cnt < 3'(N_DIGITS);
  assign restart = (state == SHOW || state == ERR) && digit;
`ifdef SUMA_BACKSPACE_EN
  assign bs = entering && bus.key_valid && bus.key_code == 4'hB && digit_cnt != 3'd0;
`else
  assign bs = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ENT_A;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ENT_A: state_nx = plus ? ENT_B : ENT_A;
      ENT_B: state_nx = eq ? REQ : ENT_B;
      REQ: state_nx = WAIT;
      WAIT: state_nx = bus.sum_done ? SHOW : tmo == TW'(TIMEOUT_CYCLES - 1) ? ERR : WAIT;
      SHOW, ERR: state_nx = digit ? ENT_A : state;
      default: state_nx = ENT_A;
    endcase
    if (clr) state_nx = ENT_A;
  end
  always_comb begin
    sum_start = state == REQ;
    error = state == ERR;
    disp_sel = state == SHOW ? 2'b10 : state == ERR ? 2'b11 : state == ENT_A ? 2'b00 : 2'b01;
  end
  // operands are only written in ENT_A/ENT_B or on restart, so they hold from REQ through SHOW
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      digit_cnt <= '0;
      tmo <= '0;
    end else if (clr) begin
      op_a <= '0;
      op_b <= '0;
      digit_cnt <= '0;
      tmo <= '0;
    end else begin
      if (shift) begin
        if (in_b) op_b <= shl;
        else op_a <= shl;
        digit_cnt <= digit_cnt + 3'd1;
      end else if (bs) begin
        if (in_b) op_b <= shr;
        else op_a <= shr;
        digit_cnt <= digit_cnt - 3'd1;
      end else if (state == ENT_A && plus) begin
        op_b <= '0;
        digit_cnt <= '0;
      end else if (restart) begin
        op_a <= W'(bus.key_code);
        op_b <= '0;
        digit_cnt <= 3'd1;
      end
      tmo <= (state == WAIT && state_nx == WAIT) ? tmo + TW'(1) : '0;
    end
  assign bus.op_a = op_a;
  assign bus.op_b = op_b;
  assign bus.digit_cnt = digit_cnt;
  assign bus.sum_start = sum_start;
  assign bus.disp_sel = disp_sel;
  assign bus.error = error;
endmodule

// File: tb/tb_suma_control.sv
// tb_suma_control: directed self-checking bench for suma_control
module tb_suma_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  int starts = 0;
  int s0;
  suma_if #(.N_DIGITS(3)) bus();
  suma_control #(.N_DIGITS(3), .TIMEOUT_CYCLES(1024)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.sum_start) starts <= starts + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic key(input logic [3:0] c);
    bus.key_valid = 1'b1;
    bus.key_code = c;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask
  task automatic done_pulse();
    bus.sum_done = 1'b1;
    @(negedge clk);
    bus.sum_done = 1'b0;
  endtask
  initial begin
    bus.key_valid = 1'b0;
    bus.key_code = 4'h0;
    bus.sum_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_op_a", bus.op_a, 0);
    chk("rst_op_b", bus.op_b, 0);
    chk("rst_cnt", bus.digit_cnt, 0);
    chk("rst_disp", bus.disp_sel, 0);
    chk("rst_start", bus.sum_start, 0);
    chk("rst_err", bus.error, 0);
    // 123 + 45
    key(4'h1); key(4'h2); key(4'h3);
    chk("a_123", bus.op_a, 12'h123);
    chk("a_cnt3", bus.digit_cnt, 3);
    key(4'hA);
    chk("plus_disp", bus.disp_sel, 2'b01);
    chk("plus_cnt", bus.digit_cnt, 0);
    key(4'h4); key(4'h5);
    chk("b_045", bus.op_b, 12'h045);
    s0 = starts;
    key(4'hE);
    chk("req_start", bus.sum_start, 1);
    @(negedge clk);
    chk("wait_nostart", bus.sum_start, 0);
    @(negedge clk);
    done_pulse();
    chk("show_disp", bus.disp_sel, 2'b10);
    chk("show_op_a", bus.op_a, 12'h123);
    chk("show_op_b", bus.op_b, 12'h045);
    chk("one_start", starts - s0, 1);
    // restart from SHOW, MSD kept when full
    key(4'h9);
    chk("restart_a", bus.op_a, 12'h009);
    chk("restart_b", bus.op_b, 0);
    chk("restart_disp", bus.disp_sel, 2'b00);
    key(4'h8); key(4'h7); key(4'h6);
    chk("full_a", bus.op_a, 12'h987);
    chk("full_cnt", bus.digit_cnt, 3);
    done_pulse();
    key(4'hE); key(4'hD); key(4'hF);
    chk("ign_disp", bus.disp_sel, 2'b00);
    chk("ign_a", bus.op_a, 12'h987);
    // timeout
    key(4'hC);
    chk("clr_a", bus.op_a, 0);
    key(4'h1); key(4'hA); key(4'h2); key(4'hE);
    repeat (1024) @(negedge clk);
    chk("to_not_yet", bus.error, 0);
    chk("to_wait_disp", bus.disp_sel, 2'b01);
    @(negedge clk);
    chk("to_err", bus.error, 1);
    chk("to_disp", bus.disp_sel, 2'b11);
    key(4'hA);
    done_pulse();
    chk("err_ign", bus.disp_sel, 2'b11);
    key(4'h5);
    chk("err_restart_a", bus.op_a, 12'h005);
    chk("err_restart_e", bus.error, 0);
    chk("err_restart_cnt", bus.digit_cnt, 1);
    // clear beats sum_done
    key(4'hC);
    key(4'h1); key(4'hA); key(4'h2); key(4'hE);
    @(negedge clk);
    bus.sum_done = 1'b1;
    key(4'hC);
    bus.sum_done = 1'b0;
    chk("cd_disp", bus.disp_sel, 2'b00);
    chk("cd_a", bus.op_a, 0);
    chk("cd_b", bus.op_b, 0);
    repeat (3) @(negedge clk);
    chk("cd_noshow", bus.disp_sel, 2'b00);
    // clear during REQ
    s0 = starts;
    key(4'h3); key(4'hA); key(4'h4); key(4'hE);
    key(4'hC);
    repeat (3) @(negedge clk);
    chk("req_clr_starts", starts - s0, 1);
    chk("req_clr_disp", bus.disp_sel, 2'b00);
    // async reset in WAIT
    key(4'h1); key(4'hA); key(4'h2); key(4'hE);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_a", bus.op_a, 0);
    chk("arst_b", bus.op_b, 0);
    chk("arst_disp", bus.disp_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    s0 = starts;
    done_pulse();
    chk("arst_done_ign", bus.disp_sel, 0);
    chk("arst_cnt", bus.digit_cnt, 0);
    chk("arst_nostart", starts - s0, 0);
    // backspace
    key(4'h1); key(4'h2); key(4'hB); key(4'h7);
`ifdef SUMA_BACKSPACE_EN
    chk("bs_a", bus.op_a, 12'h017);
    chk("bs_cnt", bus.digit_cnt, 2);
`else
    chk("bs_a", bus.op_a, 12'h127);
    chk("bs_cnt", bus.digit_cnt, 3);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
